avalon_mm_burst_master: RTL and testbench
=========================================

Name: avalon_mm_burst_master

Overview:
Command-driven Avalon-MM master that drives the team's Avalon-MM bus signal set (address, burstcount, byteenable, write/writedata, read/readdata/readdatavalid, waitrequest).
Accepts a transfer command (read or write, start address, word count) and splits it into consecutive bursts of at most MAX_BURST words.
Write data comes in on a valid/ready stream. Read data goes out on a valid-only stream.
Sits directly upstream of any Avalon-MM slave (memory controller, CSR fabric) on the same clock.

Parameters:
DATA_W, 64, data bus width in bits; DATA_B_W = DATA_W/8
ADDR_W, 12, byte address width
BURST_W, 2, burstcount width; MAX_BURST = 2**BURST_W - 1
LEN_W, 16, width of command word count

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous reset, active-low (0 = in reset)
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_write  input  1  1 = write transfer, 0 = read transfer
cmd_addr  input  ADDR_W  start byte address
cmd_len  input  LEN_W  number of DATA_W words
done  output  1  one-cycle pulse when a command completes
wr_valid  input  1  write data word present
wr_ready  output  1  write data word consumed this cycle
wr_data  input  DATA_W  write data
rd_valid  output  1  read data word valid
rd_data  output  DATA_W  read data
address  output  ADDR_W  Avalon-MM byte address
burstcount  output  BURST_W  Avalon-MM burst length
byteenable  output  DATA_B_W  always all ones
write  output  1  Avalon-MM write
writedata  output  DATA_W  Avalon-MM write data
read  output  1  Avalon-MM read
readdatavalid  input  1  Avalon-MM read data valid
readdata  input  DATA_W  Avalon-MM read data
waitrequest  input  1  Avalon-MM stall

Behaviour:
- Reset (rst=0, async): state IDLE, cmd_ready=1, done=0, rd_valid=0, write=0, read=0, address=0, burstcount=0, counters=0.
  - Any command in progress is abandoned.
  - Reads already issued are not tracked.
- States: IDLE, WR_BURST, RD_REQ, RD_WAIT.
- IDLE:
  - cmd_ready=1; handshake is cmd_valid&cmd_ready.
  - On handshake, latch the address with its low log2(DATA_B_W) bits forced to 0, and latch cmd_len as remaining.
  - If cmd_len==0: done=1 next cycle, stay IDLE, no bus activity.
  - Otherwise go to WR_BURST or RD_REQ.
  - readdatavalid is ignored in IDLE.
- Burst size bsz = min(remaining, MAX_BURST). It is computed on entry to each burst and driven on burstcount for the whole burst.
- WR_BURST:
  - write = wr_valid; writedata = wr_data (combinational pass-through); wr_ready = ~waitrequest.
  - A beat is accepted when write & ~waitrequest.
  - address and burstcount are held constant for all beats of the burst.
  - When write=1 and waitrequest=1, writedata stays equal to the held wr_data word; the stream rule requires wr_data to be stable while wr_valid & ~wr_ready.
  - After the bsz-th accepted beat:
    - remaining -= bsz
    - address += bsz*DATA_B_W, modulo 2**ADDR_W
    - if remaining>0, start the next burst in WR_BURST next cycle; otherwise go to IDLE with done=1 for one cycle.
- RD_REQ:
  - read=1 with address and burstcount until a cycle with ~waitrequest, then go to RD_WAIT.
  - address advances and remaining decrements as for writes.
- RD_WAIT:
  - read=0; count readdatavalid beats.
  - rd_valid/rd_data are the registered readdatavalid/readdata (1-cycle latency, no backpressure).
  - readdatavalid may arrive the cycle after the request is accepted.
  - After bsz beats: if remaining>0 go to RD_REQ; otherwise go to IDLE with done=1 in the same cycle as the last rd_valid.
- Only one burst is outstanding at a time; the next read request waits for all data of the current burst.
- cmd_ready=0 outside IDLE. It returns to 1 in the cycle done=1, so a new command can be accepted in that cycle.
- In WR_BURST, wr_ready=0 while waitrequest=1.

Test Plan:
- Write 7 words at 0x100, BURST_W=2, waitrequest=0, wr_valid=1 -> three bursts: 0x100/count 3, 0x118/count 3, 0x130/count 1. 7 wr_ready beats, data in order, done pulses once after beat 7.
- Read 4 words at 0x040, slave latency 2 -> RD_REQ 0x040/count 3, then RD_REQ 0x058/count 1 only after 3 readdatavalid beats. 4 rd_valid pulses, each one cycle after readdatavalid. done coincides with the 4th rd_valid.
- Write burst with waitrequest high for 3 cycles on beat 2 -> write stays 1, address/burstcount/writedata stable, wr_ready=0 for those cycles. Beat count is still exactly bsz.
- cmd_len=0 -> done=1 the cycle after the handshake; read/write never assert; cmd_ready stays 1.
- Write 4 words at 0xFF0 -> bursts 0xFF0/count 3 and 0x008/count 1 (address wrap); cmd_addr=0xFF3 is treated as 0xFF0.
- Reset asserted in RD_WAIT after 1 of 3 beats -> outputs return to reset values immediately. Stray readdatavalid after release gives no rd_valid. The next command completes normally.

Source files
------------

// File: rtl/avalon_mm_burst_master_if.sv
// Avalon-MM master-to-slave signal bundle used by avalon_mm_burst_master.
interface avalon_mm_burst_master_if #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned BURST_W = 2
);
    localparam int unsigned DATA_B_W = DATA_W / 8;

    logic [ADDR_W-1:0]   address;
    logic [BURST_W-1:0]  burstcount;
    logic [DATA_B_W-1:0] byteenable;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                read;
    logic                readdatavalid;
    logic [DATA_W-1:0]   readdata;
    logic                waitrequest;

    modport master (
        output address, burstcount, byteenable, write, writedata, read,
        input  readdatavalid, readdata, waitrequest
    );

    modport slave (
        input  address, burstcount, byteenable, write, writedata, read,
        output readdatavalid, readdata, waitrequest
    );
endinterface

// File: rtl/avalon_mm_burst_master.sv
// Command-driven Avalon-MM burst master: splits a read/write command into
// consecutive bursts of at most MAX_BURST words, one burst outstanding at a time.
module avalon_mm_burst_master #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned BURST_W = 2,
    parameter int unsigned LEN_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [LEN_W-1:0]     cmd_len,
    output logic                 done,

    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DATA_W-1:0]    wr_data,

    output logic                 rd_valid,
    output logic [DATA_W-1:0]    rd_data,

    avalon_mm_burst_master_if.master bus
);
    localparam int unsigned DATA_B_W  = DATA_W / 8;
    localparam int unsigned ALIGN_W   = $clog2(DATA_B_W);
    localparam int unsigned MAX_BURST = (1 << BURST_W) - 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_REQ   = 2'd2,
        RD_WAIT  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic [BURST_W-1:0]   bsz_q, bsz_d;
    logic [BURST_W-1:0]   beat_q, beat_d;
    logic                 read_q, read_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 done_q, done_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]    rd_data_q, rd_data_d;

    logic [LEN_W-1:0]     rem_next;
    logic [ADDR_W-1:0]    addr_next;
    logic                 last_beat;
    logic                 burst_end;
    logic                 wr_accept;

    // Sub-word address bits are discarded; the bus is word-aligned.
    logic                 unused_addr_lsb;
    assign unused_addr_lsb = ^cmd_addr[ALIGN_W-1:0];

    function automatic logic [BURST_W-1:0] burst_size(input logic [LEN_W-1:0] rem);
        if (rem > LEN_W'(MAX_BURST)) begin
            return BURST_W'(MAX_BURST);
        end
        return BURST_W'(rem);
    endfunction

    assign wr_accept = (state_q == WR_BURST) && wr_valid && !bus.waitrequest;

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        bsz_d       = bsz_q;
        beat_d      = beat_q;
        read_d      = read_q;
        done_d      = 1'b0;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        burst_end   = 1'b0;
        rem_next    = rem_q - LEN_W'(bsz_q);
        addr_next   = addr_q + (ADDR_W'(bsz_q) << ALIGN_W);
        last_beat   = (beat_q == (bsz_q - BURST_W'(1)));

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d = {cmd_addr[ADDR_W-1:ALIGN_W], ALIGN_W'(0)};
                    rem_d  = cmd_len;
                    bsz_d  = burst_size(cmd_len);
                    beat_d = '0;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else if (cmd_write) begin
                        state_d = WR_BURST;
                    end else begin
                        state_d = RD_REQ;
                        read_d  = 1'b1;
                    end
                end
            end
            WR_BURST: begin
                if (wr_accept) begin
                    if (last_beat) begin
                        burst_end = 1'b1;
                    end else begin
                        beat_d = beat_q + BURST_W'(1);
                    end
                end
            end
            RD_REQ: begin
                if (!bus.waitrequest) begin
                    read_d  = 1'b0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.readdatavalid) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = bus.readdata;
                    if (last_beat) begin
                        burst_end = 1'b1;
                    end else begin
                        beat_d = beat_q + BURST_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Burst boundary: advance window, then either finish or start the next burst.
        if (burst_end) begin
            beat_d = '0;
            rem_d  = rem_next;
            addr_d = addr_next;
            bsz_d  = burst_size(rem_next);
            if (rem_next == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (state_q == RD_WAIT) begin
                state_d = RD_REQ;
                read_d  = 1'b1;
            end
        end

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            bsz_q       <= '0;
            beat_q      <= '0;
            read_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            bsz_q       <= bsz_d;
            beat_q      <= beat_d;
            read_q      <= read_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign done           = done_q;
    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign wr_ready       = (state_q == WR_BURST) && !bus.waitrequest;

    assign bus.address    = addr_q;
    assign bus.burstcount = bsz_q;
    assign bus.byteenable = '1;
    assign bus.read       = read_q;
    // Write data is a straight pass-through of the input stream.
    assign bus.write      = (state_q == WR_BURST) && wr_valid;
    assign bus.writedata  = wr_data;
endmodule

// File: tb/tb_avalon_mm_burst_master.sv
// Directed self-checking bench for avalon_mm_burst_master with a small
// write source, a latency-configurable read slave and an event logger.
`timescale 1ns/1ps
module tb_avalon_mm_burst_master;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned LEN_W   = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                cmd_valid, cmd_ready, cmd_write, done;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [LEN_W-1:0]    cmd_len;
    logic                wr_valid, wr_ready;
    logic [DATA_W-1:0]   wr_data;
    logic                rd_valid;
    logic [DATA_W-1:0]   rd_data;

    avalon_mm_burst_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) bus ();

    avalon_mm_burst_master #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .done(done),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .bus(bus.master)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_lat = 2;
    int wait_n = 0;
    int beats_n = 0;
    int wr_hs_n = 0;
    int bus_act_n = 0;
    logic wr_acc;
    logic [DATA_W-1:0] rd_word;

    logic [ADDR_W-1:0]  wa_q[$];
    logic [BURST_W-1:0] wb_q[$];
    logic [DATA_W-1:0]  wd_q[$];
    int                 wc_q[$];
    logic [ADDR_W-1:0]  ra_q[$];
    logic [BURST_W-1:0] rb_q[$];
    int                 ra_cyc[$];
    int                 rdv_cyc[$];
    logic [DATA_W-1:0]  rv_q[$];
    int                 rv_cyc[$];
    int                 done_cyc[$];
    logic               done_rdy[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Event logger, sampled mid-low-phase when everything is settled.
    initial forever begin
        @(negedge clk);
        #2;
        if (bus.write && !bus.waitrequest) begin
            wa_q.push_back(bus.address);
            wb_q.push_back(bus.burstcount);
            wd_q.push_back(bus.writedata);
            wc_q.push_back(cyc);
        end
        if (wr_valid && wr_ready) wr_hs_n++;
        if (bus.read || bus.write) bus_act_n++;
        if (bus.read && !bus.waitrequest) begin
            ra_q.push_back(bus.address);
            rb_q.push_back(bus.burstcount);
            ra_cyc.push_back(cyc);
        end
        if (bus.readdatavalid) rdv_cyc.push_back(cyc);
        if (rd_valid) begin
            rv_q.push_back(rd_data);
            rv_cyc.push_back(cyc);
        end
        if (done) begin
            done_cyc.push_back(cyc);
            done_rdy.push_back(cmd_ready);
        end
    end

    // Write source: advance to the next word after each accepted beat.
    initial begin
        wr_data = 64'hD000_0000_0000_0000;
        forever begin
            @(negedge clk);
            wr_acc = wr_valid && wr_ready;
            @(posedge clk);
            #1;
            if (wr_acc) wr_data = wr_data + 64'd1;
        end
    end

    // Read slave: returns burstcount words rd_lat cycles after request acceptance.
    initial begin
        bus.readdatavalid = 1'b0;
        bus.readdata      = '0;
        rd_word           = 64'hA000_0000_0000_0000;
        forever begin
            @(negedge clk);
            bus.readdatavalid = 1'b0;
            if (beats_n > 0) begin
                if (wait_n > 0) wait_n--;
                if (wait_n == 0) begin
                    bus.readdatavalid = 1'b1;
                    bus.readdata      = rd_word;
                    rd_word           = rd_word + 64'd1;
                    beats_n--;
                end
            end else if (bus.read && !bus.waitrequest) begin
                beats_n = int'(bus.burstcount);
                wait_n  = rd_lat;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len);
        check_eq("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = len;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int budget);
        int k;
        k = 0;
        while (done_cyc.size() == n0 && k < budget) begin
            step();
            k++;
        end
        check_eq("done_seen", 64'(done_cyc.size() > n0), 64'd1);
    endtask

    int b_w, b_d, b_ra, b_rv, b_rdv, hs0, act0;
    logic [DATA_W-1:0] d0, r0;
    logic [ADDR_W-1:0] exp_a;
    logic [BURST_W-1:0] exp_b;

    initial begin
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0;
        bus.waitrequest = 1'b0;
        #12;
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_rd_valid", 64'(rd_valid), 64'd0);
        check_eq("rst_read", 64'(bus.read), 64'd0);
        check_eq("rst_write", 64'(bus.write), 64'd0);
        check_eq("rst_address", 64'(bus.address), 64'd0);
        check_eq("rst_burstcount", 64'(bus.burstcount), 64'd0);
        check_eq("byteenable", 64'(bus.byteenable), 64'hFF);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Write 7 words at 0x100 with no stalls.
        b_w = wa_q.size(); b_d = done_cyc.size(); hs0 = wr_hs_n; d0 = wr_data;
        wr_valid = 1'b1;
        send_cmd(1'b1, 12'h100, 16'd7);
        wait_done(b_d, 50);
        wr_valid = 1'b0;
        step(); step();
        check_eq("t1_beats", 64'(wa_q.size() - b_w), 64'd7);
        check_eq("t1_wr_hs", 64'(wr_hs_n - hs0), 64'd7);
        for (int i = 0; i < 7; i++) begin
            exp_a = (i < 3) ? 12'h100 : (i < 6) ? 12'h118 : 12'h130;
            exp_b = (i < 6) ? 2'd3 : 2'd1;
            check_eq($sformatf("t1_addr%0d", i), 64'(wa_q[b_w+i]), 64'(exp_a));
            check_eq($sformatf("t1_bcnt%0d", i), 64'(wb_q[b_w+i]), 64'(exp_b));
            check_eq($sformatf("t1_data%0d", i), wd_q[b_w+i], d0 + 64'(i));
        end
        check_eq("t1_done_n", 64'(done_cyc.size() - b_d), 64'd1);
        check_eq("t1_done_t", 64'(done_cyc[b_d]), 64'(wc_q[b_w+6] + 1));
        check_eq("t1_done_rdy", 64'(done_rdy[b_d]), 64'd1);

        // Read 4 words at 0x040, slave latency 2.
        rd_lat = 2;
        b_ra = ra_q.size(); b_rv = rv_q.size(); b_rdv = rdv_cyc.size(); b_d = done_cyc.size();
        r0 = rd_word;
        send_cmd(1'b0, 12'h040, 16'd4);
        wait_done(b_d, 60);
        step(); step();
        check_eq("t2_req_n", 64'(ra_q.size() - b_ra), 64'd2);
        check_eq("t2_req0_addr", 64'(ra_q[b_ra]), 64'h040);
        check_eq("t2_req0_bcnt", 64'(rb_q[b_ra]), 64'd3);
        check_eq("t2_req1_addr", 64'(ra_q[b_ra+1]), 64'h058);
        check_eq("t2_req1_bcnt", 64'(rb_q[b_ra+1]), 64'd1);
        check_eq("t2_lat", 64'(rdv_cyc[b_rdv] - ra_cyc[b_ra]), 64'd2);
        check_eq("t2_req1_after", 64'(ra_cyc[b_ra+1] > rdv_cyc[b_rdv+2]), 64'd1);
        check_eq("t2_rv_n", 64'(rv_q.size() - b_rv), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t2_rdata%0d", i), rv_q[b_rv+i], r0 + 64'(i));
            check_eq($sformatf("t2_rv_t%0d", i), 64'(rv_cyc[b_rv+i]), 64'(rdv_cyc[b_rdv+i] + 1));
        end
        check_eq("t2_done_n", 64'(done_cyc.size() - b_d), 64'd1);
        check_eq("t2_done_t", 64'(done_cyc[b_d]), 64'(rv_cyc[b_rv+3]));

        // Write 3 words with waitrequest held high for 3 cycles on beat 2.
        b_w = wa_q.size(); b_d = done_cyc.size(); hs0 = wr_hs_n; d0 = wr_data;
        wr_valid = 1'b1;
        send_cmd(1'b1, 12'h300, 16'd3);
        step();
        bus.waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("t3_write%0d", i), 64'(bus.write), 64'd1);
            check_eq($sformatf("t3_wr_ready%0d", i), 64'(wr_ready), 64'd0);
            check_eq($sformatf("t3_addr%0d", i), 64'(bus.address), 64'h300);
            check_eq($sformatf("t3_bcnt%0d", i), 64'(bus.burstcount), 64'd3);
            check_eq($sformatf("t3_wdata%0d", i), bus.writedata, d0 + 64'd1);
            step();
        end
        bus.waitrequest = 1'b0;
        wait_done(b_d, 30);
        wr_valid = 1'b0;
        step();
        check_eq("t3_beats", 64'(wa_q.size() - b_w), 64'd3);
        check_eq("t3_wr_hs", 64'(wr_hs_n - hs0), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("t3_data%0d", i), wd_q[b_w+i], d0 + 64'(i));
        end

        // Zero-length command: done only, no bus activity.
        act0 = bus_act_n; b_d = done_cyc.size();
        wr_valid = 1'b1;
        send_cmd(1'b1, 12'h500, 16'd0);
        check_eq("t4_done_hi", 64'(done), 64'd1);
        check_eq("t4_cmd_ready_hi", 64'(cmd_ready), 64'd1);
        step();
        check_eq("t4_done_lo", 64'(done), 64'd0);
        check_eq("t4_cmd_ready", 64'(cmd_ready), 64'd1);
        step(); step();
        wr_valid = 1'b0;
        check_eq("t4_bus_idle", 64'(bus_act_n - act0), 64'd0);
        check_eq("t4_done_n", 64'(done_cyc.size() - b_d), 64'd1);

        // Write 4 words at unaligned 0xFF3: address wraps after the first burst.
        b_w = wa_q.size(); b_d = done_cyc.size(); d0 = wr_data;
        wr_valid = 1'b1;
        send_cmd(1'b1, 12'hFF3, 16'd4);
        wait_done(b_d, 40);
        wr_valid = 1'b0;
        step();
        check_eq("t5_beats", 64'(wa_q.size() - b_w), 64'd4);
        for (int i = 0; i < 4; i++) begin
            exp_a = (i < 3) ? 12'hFF0 : 12'h008;
            exp_b = (i < 3) ? 2'd3 : 2'd1;
            check_eq($sformatf("t5_addr%0d", i), 64'(wa_q[b_w+i]), 64'(exp_a));
            check_eq($sformatf("t5_bcnt%0d", i), 64'(wb_q[b_w+i]), 64'(exp_b));
            check_eq($sformatf("t5_data%0d", i), wd_q[b_w+i], d0 + 64'(i));
        end

        // Reset mid-read after the first of three beats.
        rd_lat = 1;
        b_rv = rv_q.size(); b_rdv = rdv_cyc.size(); b_d = done_cyc.size();
        send_cmd(1'b0, 12'h080, 16'd3);
        for (int k = 0; k < 20 && rdv_cyc.size() == b_rdv; k++) step();
        check_eq("t6_first_beat", 64'(rdv_cyc.size() - b_rdv), 64'd1);
        rst = 1'b0;
        #1;
        check_eq("t6_rd_valid", 64'(rd_valid), 64'd0);
        check_eq("t6_read", 64'(bus.read), 64'd0);
        check_eq("t6_write", 64'(bus.write), 64'd0);
        check_eq("t6_address", 64'(bus.address), 64'd0);
        check_eq("t6_burstcount", 64'(bus.burstcount), 64'd0);
        check_eq("t6_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("t6_done", 64'(done), 64'd0);
        #1;
        rst = 1'b1;
        repeat (4) step();
        check_eq("t6_strays_seen", 64'(rdv_cyc.size() - b_rdv), 64'd3);
        check_eq("t6_no_rd_valid", 64'(rv_q.size() - b_rv), 64'd0);
        check_eq("t6_no_done", 64'(done_cyc.size() - b_d), 64'd0);

        // Next command after reset completes normally.
        b_ra = ra_q.size(); b_rv = rv_q.size(); b_d = done_cyc.size();
        r0 = rd_word;
        send_cmd(1'b0, 12'h0C0, 16'd2);
        wait_done(b_d, 30);
        step();
        check_eq("t7_req_n", 64'(ra_q.size() - b_ra), 64'd1);
        check_eq("t7_req_addr", 64'(ra_q[b_ra]), 64'h0C0);
        check_eq("t7_req_bcnt", 64'(rb_q[b_ra]), 64'd2);
        check_eq("t7_rv_n", 64'(rv_q.size() - b_rv), 64'd2);
        check_eq("t7_rdata0", rv_q[b_rv], r0);
        check_eq("t7_rdata1", rv_q[b_rv+1], r0 + 64'd1);
        check_eq("t7_done_t", 64'(done_cyc[b_d]), 64'(rv_cyc[b_rv+1]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
